hit_resolver: RTL and testbench

HIT_RESOLVER -- requirements
Module: hit_resolver

---
 rtl/fighter_pkg.sv | 39 +++
 rtl/hitbox_overlap.sv | 34 +++
 rtl/hit_resolver.sv | 144 ++++++++++++++
 tb/tb_hit_resolver.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fighter_pkg.sv
// Shared constants, state encoding and attack-type encodings for the hit
// resolution logic: box geometry, damage, health and hitstun parameters.
package fighter_pkg;

  localparam int unsigned POS_W    = 10;  // screen coordinate width
  localparam int unsigned GEO_W    = 11;  // widened geometry math width
  localparam int unsigned HEALTH_W = 7;
  localparam int unsigned STUN_W   = 4;

  localparam int unsigned BOX_W  = 60;
  localparam int unsigned BOX_H  = 60;
  localparam int unsigned ATK1_W = 30;
  localparam int unsigned ATK1_H = 60;
  localparam int unsigned ATK2_W = 60;
  localparam int unsigned ATK2_H = 60;

  localparam int unsigned DMG1           = 10;
  localparam int unsigned DMG2           = 20;
  localparam int unsigned HEALTH_MAX     = 100;
  localparam int unsigned HITSTUN_FRAMES = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_LANDED = 2'd2,
    ST_KO     = 2'd3
  } state_e;

  localparam logic [1:0] ATK_NONE  = 2'd0;
  localparam logic [1:0] ATK_LIGHT = 2'd1;
  localparam logic [1:0] ATK_HEAVY = 2'd2;
  localparam logic [1:0] ATK_NONE3 = 2'd3;

  // Only light and heavy encodings describe a real attack.
  function automatic logic atk_valid(input logic [1:0] t);
    return (t == ATK_LIGHT) || (t == ATK_HEAVY);
  endfunction

endpackage

// File: rtl/hitbox_overlap.sv
// Strict half-open rectangle intersection: [x, x+w) x [y, y+h).
// Touching edges do not overlap.
// Ports: atk_x/y/w/h - attack box; def_x/y/w/h - defender box;
//        overlap      - boxes share at least one pixel.
module hitbox_overlap
  import fighter_pkg::*;
(
  input  logic [GEO_W-1:0] atk_x,
  input  logic [GEO_W-1:0] atk_y,
  input  logic [GEO_W-1:0] atk_w,
  input  logic [GEO_W-1:0] atk_h,
  input  logic [GEO_W-1:0] def_x,
  input  logic [GEO_W-1:0] def_y,
  input  logic [GEO_W-1:0] def_w,
  input  logic [GEO_W-1:0] def_h,
  output logic             overlap
);

  logic [GEO_W-1:0] atk_x_end;
  logic [GEO_W-1:0] atk_y_end;
  logic [GEO_W-1:0] def_x_end;
  logic [GEO_W-1:0] def_y_end;

  // Coordinates stay below 1024+120, so 11-bit sums never wrap.
  always_comb begin
    atk_x_end = atk_x + atk_w;
    atk_y_end = atk_y + atk_h;
    def_x_end = def_x + def_w;
    def_y_end = def_y + def_h;
    overlap   = (atk_x < def_x_end) && (def_x < atk_x_end) &&
                (atk_y < def_y_end) && (def_y < atk_y_end);
  end

endmodule

// File: rtl/hit_resolver.sv
// Resolves attacker hits against a defender once per frame (SCEN): tracks
// defender health, hitstun and KO. Optional macro HIT_BLOCK_EN adds the
// def_blocking input (blocked hits deal DMG>>2 and load no hitstun).
// Ports: clk, reset_n (async active-low), SCEN frame tick,
//        attack_active/attack_type/atk_facing_right, atk_pos_x/y, def_pos_x/y,
//        [def_blocking], hit_pulse, def_health, hitstun_active, ko.
module hit_resolver
  import fighter_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                SCEN,
  input  logic                attack_active,
  input  logic [1:0]          attack_type,
  input  logic                atk_facing_right,
  input  logic [POS_W-1:0]    atk_pos_x,
  input  logic [POS_W-1:0]    atk_pos_y,
  input  logic [POS_W-1:0]    def_pos_x,
  input  logic [POS_W-1:0]    def_pos_y,
`ifdef HIT_BLOCK_EN
  input  logic                def_blocking,
`endif
  output logic                hit_pulse,
  output logic [HEALTH_W-1:0] def_health,
  output logic                hitstun_active,
  output logic                ko
);

  state_e              state_q, state_d;
  logic [HEALTH_W-1:0] health_q, health_d;
  logic [STUN_W-1:0]   stun_q, stun_d;
  logic                hit_pulse_q, hit_pulse_d;
  logic                hitstun_active_q, hitstun_active_d;
  logic                ko_q, ko_d;

  logic [GEO_W-1:0]    atk_w_c, atk_h_c, ax_ext_c, box_x_c, box_w_c;
  logic                overlap_c;
  logic                blocked_c;
  logic                eval_c;
  logic [HEALTH_W-1:0] dmg_c;

`ifdef HIT_BLOCK_EN
  assign blocked_c = def_blocking;
`else
  assign blocked_c = 1'b0;
`endif

  // Attack box placement; a left-facing box near x=0 shrinks rather than wraps.
  always_comb begin
    atk_w_c  = (attack_type == ATK_HEAVY) ? GEO_W'(ATK2_W) : GEO_W'(ATK1_W);
    atk_h_c  = (attack_type == ATK_HEAVY) ? GEO_W'(ATK2_H) : GEO_W'(ATK1_H);
    ax_ext_c = GEO_W'(atk_pos_x);
    box_x_c  = '0;
    box_w_c  = atk_w_c;
    if (atk_facing_right) begin
      box_x_c = ax_ext_c + GEO_W'(BOX_W);
    end else if (ax_ext_c >= atk_w_c) begin
      box_x_c = ax_ext_c - atk_w_c;
    end else begin
      box_w_c = ax_ext_c;
    end
  end

  hitbox_overlap u_overlap (
    .atk_x   (box_x_c),
    .atk_y   (GEO_W'(atk_pos_y)),
    .atk_w   (box_w_c),
    .atk_h   (atk_h_c),
    .def_x   (GEO_W'(def_pos_x)),
    .def_y   (GEO_W'(def_pos_y)),
    .def_w   (GEO_W'(BOX_W)),
    .def_h   (GEO_W'(BOX_H)),
    .overlap (overlap_c)
  );

  // Damage for the type sampled at the landing frame; blocking quarters it.
  always_comb begin
    dmg_c = (attack_type == ATK_HEAVY) ? HEALTH_W'(DMG2) : HEALTH_W'(DMG1);
    if (blocked_c) dmg_c = dmg_c >> 2;
  end

  // Next-state, health and hitstun; everything advances only on SCEN.
  always_comb begin
    state_d     = state_q;
    health_d    = health_q;
    stun_d      = stun_q;
    hit_pulse_d = 1'b0;
    eval_c      = 1'b0;
    if (SCEN) begin
      if (stun_q != '0) stun_d = stun_q - STUN_W'(1);
      case (state_q)
        // Arming frame also evaluates overlap so first-frame hits count.
        ST_IDLE: if (attack_active && atk_valid(attack_type)) begin
          state_d = ST_ARMED;
          eval_c  = 1'b1;
        end
        ST_ARMED: begin
          if (!attack_active) state_d = ST_IDLE;
          else                eval_c  = 1'b1;
        end
        ST_LANDED: if (!attack_active) state_d = ST_IDLE;
        ST_KO: ;
        default: state_d = ST_IDLE;
      endcase
      if (eval_c && overlap_c) begin
        // Landing consumes the attack; damage only outside hitstun.
        state_d = ST_LANDED;
        if ((stun_q == '0) && atk_valid(attack_type)) begin
          health_d    = (health_q > dmg_c) ? (health_q - dmg_c) : '0;
          hit_pulse_d = 1'b1;
          if (!blocked_c) stun_d = STUN_W'(HITSTUN_FRAMES);
          if (health_d == '0) state_d = ST_KO;
        end
      end
    end
    hitstun_active_d = (stun_d != '0);
    ko_d             = (state_d == ST_KO);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      health_q         <= HEALTH_W'(HEALTH_MAX);
      stun_q           <= '0;
      hit_pulse_q      <= 1'b0;
      hitstun_active_q <= 1'b0;
      ko_q             <= 1'b0;
    end else begin
      state_q          <= state_d;
      health_q         <= health_d;
      stun_q           <= stun_d;
      hit_pulse_q      <= hit_pulse_d;
      hitstun_active_q <= hitstun_active_d;
      ko_q             <= ko_d;
    end
  end

  assign hit_pulse      = hit_pulse_q;
  assign def_health     = health_q;
  assign hitstun_active = hitstun_active_q;
  assign ko             = ko_q;

endmodule

// File: tb/tb_hit_resolver.sv
// Directed bench for hit_resolver: geometry edges, single-hit-per-attack,
// hitstun timing, KO, asynchronous reset and (with HIT_BLOCK_EN) blocking.
module tb_hit_resolver;
  import fighter_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       SCEN;
  logic       attack_active;
  logic [1:0] attack_type;
  logic       atk_facing_right;
  logic [9:0] atk_pos_x, atk_pos_y, def_pos_x, def_pos_y;
`ifdef HIT_BLOCK_EN
  logic       def_blocking;
`endif
  logic       hit_pulse;
  logic [6:0] def_health;
  logic       hitstun_active;
  logic       ko;

  int checks   = 0;
  int failures = 0;
  int pulse_cnt = 0;
  int base;

  hit_resolver dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .SCEN             (SCEN),
    .attack_active    (attack_active),
    .attack_type      (attack_type),
    .atk_facing_right (atk_facing_right),
    .atk_pos_x        (atk_pos_x),
    .atk_pos_y        (atk_pos_y),
    .def_pos_x        (def_pos_x),
    .def_pos_y        (def_pos_y),
`ifdef HIT_BLOCK_EN
    .def_blocking     (def_blocking),
`endif
    .hit_pulse        (hit_pulse),
    .def_health       (def_health),
    .hitstun_active   (hitstun_active),
    .ko               (ko)
  );

  always #5 clk = ~clk;

  // Counts every clock cycle on which hit_pulse is high.
  always @(negedge clk) pulse_cnt <= pulse_cnt + (hit_pulse ? 1 : 0);

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One frame: SCEN high for exactly one posedge; returns on the following
  // negedge, where that frame's registered results are visible.
  task automatic frame();
    @(negedge clk);
    SCEN = 1'b1;
    @(negedge clk);
    SCEN = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1; SCEN = 1'b0; attack_active = 1'b0; attack_type = 2'd0;
    atk_facing_right = 1'b1; atk_pos_x = 10'd200; atk_pos_y = 10'd100;
    def_pos_x = 10'd600; def_pos_y = 10'd100;
`ifdef HIT_BLOCK_EN
    def_blocking = 1'b0;
`endif
    #3 reset_n = 1'b0;
    #2;
    check("rst_health", 32'(def_health), 100);
    check("rst_stun", 32'(hitstun_active), 0);
    check("rst_ko", 32'(ko), 0);
    check("rst_pulse", 32'(hit_pulse), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Light hit on first active frame, right-facing, defender at 260.
    def_pos_x = 10'd260; attack_type = 2'd1; attack_active = 1'b1;
    base = pulse_cnt;
    frame();
    check("first_pulse", 32'(hit_pulse), 1);
    check("first_health", 32'(def_health), 90);
    check("first_stun", 32'(hitstun_active), 1);
    check("first_ko", 32'(ko), 0);
    settle();
    check("pulse_width", 32'(hit_pulse), 0);
    check("pulse_count", pulse_cnt - base, 1);
    attack_active = 1'b0;
    frames(11);
    check("stun_11", 32'(hitstun_active), 1);
    frame();
    check("stun_12", 32'(hitstun_active), 0);
    // Inputs without SCEN must not change anything.
    attack_active = 1'b1;
    repeat (5) @(negedge clk);
    check("no_scen", 32'(def_health), 90);
    attack_active = 1'b0;
    frame();

    // Touching x edge: attack [260,290), defender [290,350).
    do_reset();
    def_pos_x = 10'd290; attack_active = 1'b1; base = pulse_cnt;
    frames(3);
    check("touch_x_health", 32'(def_health), 100);
    settle();
    check("touch_x_pulses", pulse_cnt - base, 0);
    attack_active = 1'b0; frame();
    // One-pixel overlap at the far defender edge: defender [201,261).
    def_pos_x = 10'd201; attack_active = 1'b1;
    frame();
    check("one_px_health", 32'(def_health), 90);
    attack_active = 1'b0; frames(13);

    // Touching y edge: attack y [100,160), defender y [160,220).
    do_reset();
    def_pos_x = 10'd260; def_pos_y = 10'd160; attack_active = 1'b1;
    frames(2);
    check("touch_y_health", 32'(def_health), 100);
    attack_active = 1'b0; frame();
    def_pos_y = 10'd100;

    // Left-facing heavy held 5 frames: attack [240,300), defender [250,310).
    do_reset();
    atk_pos_x = 10'd300; atk_facing_right = 1'b0; attack_type = 2'd2;
    def_pos_x = 10'd250; attack_active = 1'b1; base = pulse_cnt;
    frames(5);
    check("left_heavy_health", 32'(def_health), 80);
    settle();
    check("left_heavy_pulses", pulse_cnt - base, 1);
    attack_active = 1'b0; frame(); frames(12);
    // Clamped left box [0,20): defender at 20 touches, at 0 overlaps.
    atk_pos_x = 10'd20; def_pos_x = 10'd20; attack_active = 1'b1;
    frame();
    check("clamp_touch", 32'(def_health), 80);
    def_pos_x = 10'd0;
    frame();
    check("clamp_hit", 32'(def_health), 60);
    attack_active = 1'b0; frames(14);

    // attack_active falling on the overlap frame suppresses the hit.
    do_reset();
    atk_pos_x = 10'd200; atk_facing_right = 1'b1; attack_type = 2'd1;
    def_pos_x = 10'd600; attack_active = 1'b1;
    frame();
    def_pos_x = 10'd260; attack_active = 1'b0;
    frame();
    check("fall_same_frame", 32'(def_health), 100);
    // Type switched while armed: heavy damage at landing.
    def_pos_x = 10'd600; attack_active = 1'b1;
    frame();
    attack_type = 2'd2; def_pos_x = 10'd260;
    frame();
    check("type_switch", 32'(def_health), 80);
    attack_active = 1'b0; frames(14);

    // Hit during hitstun is consumed; later hit after expiry lands.
    do_reset();
    attack_type = 2'd1; attack_active = 1'b1;
    frame();
    check("stun_first", 32'(def_health), 90);
    attack_active = 1'b0; frames(4);
    attack_active = 1'b1; base = pulse_cnt;
    frame();
    check("stun_consumed", 32'(def_health), 90);
    check("stun_landed", 32'(dut.state_q), 32'(ST_LANDED));
    frames(15);
    check("landed_hold", 32'(def_health), 90);
    settle();
    check("stun_no_pulse", pulse_cnt - base, 0);
    attack_active = 1'b0; frame();
    check("stun_expired", 32'(hitstun_active), 0);
    attack_active = 1'b1;
    frame();
    check("after_stun", 32'(def_health), 80);
    attack_active = 1'b0; frame();

    // Five heavy hits 20 frames apart reach KO; sixth is ignored.
    do_reset();
    attack_type = 2'd2; base = pulse_cnt;
    for (int k = 1; k <= 5; k++) begin
      attack_active = 1'b1;
      frame();
      check("ko_seq_health", 32'(def_health), 100 - 20 * k);
      check("ko_seq_pulse", 32'(hit_pulse), 1);
      check("ko_seq_ko", 32'(ko), (k == 5) ? 1 : 0);
      attack_active = 1'b0;
      frames(19);
    end
    attack_active = 1'b1;
    frames(3);
    check("ko_sixth_health", 32'(def_health), 0);
    check("ko_sixth_ko", 32'(ko), 1);
    settle();
    check("ko_pulses", pulse_cnt - base, 5);
    attack_active = 1'b0; frame();

    // Reset mid-hitstun clears outputs at once; held attack re-arms after.
    do_reset();
    attack_type = 2'd1; attack_active = 1'b1;
    frame();
    check("pre_rst_health", 32'(def_health), 90);
    #1 reset_n = 1'b0;
    #1;
    check("async_health", 32'(def_health), 100);
    check("async_pulse", 32'(hit_pulse), 0);
    check("async_stun", 32'(hitstun_active), 0);
    check("async_ko", 32'(ko), 0);
    @(negedge clk);
    reset_n = 1'b1;
    frame();
    check("rearm_health", 32'(def_health), 90);
    attack_active = 1'b0; frame();

`ifdef HIT_BLOCK_EN
    // Blocked hits: quarter damage, pulse fires, no hitstun.
    do_reset();
    def_blocking = 1'b1; attack_type = 2'd2; attack_active = 1'b1;
    frame();
    check("blk_heavy_health", 32'(def_health), 95);
    check("blk_heavy_pulse", 32'(hit_pulse), 1);
    check("blk_heavy_stun", 32'(hitstun_active), 0);
    attack_active = 1'b0; frame();
    attack_type = 2'd1; attack_active = 1'b1;
    frame();
    check("blk_light_health", 32'(def_health), 93);
    attack_active = 1'b0; def_blocking = 1'b0; frame();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
